// File: rtl/seg_scan_ctrl_if.sv
// Value handshake between the counter logic (master) and the display scanner (slave).
interface seg_scan_ctrl_if;
  logic [11:0] i_val;
  logic        i_val_valid;
  logic        o_val_ready;

  modport master (output i_val, output i_val_valid, input  o_val_ready);
  modport slave  (input  i_val, input  i_val_valid, output o_val_ready);
endinterface

// File: rtl/seg_scan_ctrl.sv
// Three-digit seven-segment scan scheduler: double-buffered BCD value,
// per-slot blanking window, digit mask and leading-zero blanking.
module seg_scan_ctrl #(
  parameter int unsigned SCAN_DIV  = 100_000,
  parameter int unsigned BLANK_CYC = 1_000
) (
  input  logic                  i_clk_fpga,
  input  logic                  reset,
  seg_scan_ctrl_if.slave        val_if,
  input  logic [2:0]            i_dig_mask,
  input  logic                  i_lzb,
  output logic [3:0]            o_digit,
  output logic [2:0]            o_seg_en,
  output logic                  o_frame_start
);

  localparam int unsigned PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  typedef logic [PW-1:0] phase_t;
  localparam phase_t PHASE_LAST = phase_t'(SCAN_DIV - 1);
  localparam phase_t BLANK_END  = phase_t'(BLANK_CYC);

  typedef enum logic [1:0] {
    SLOT0 = 2'd0,
    SLOT1 = 2'd1,
    SLOT2 = 2'd2
  } slot_t;

  slot_t       slot, slot_nxt;
  phase_t      phase, phase_nxt;
  logic        phase_wrap;
  logic        frame_bnd;

  logic [11:0] disp_reg;
  logic [11:0] pend_reg;
  logic        pend_flag;
  logic        xfer;

  logic [3:0]  nib;
  logic [2:0]  onehot;
  logic        mask_bit;
  logic        lzb_blank;
  logic        in_blank;
  logic [2:0]  seg_nxt;

  // Slot/phase scan sequencer
  always_ff @(posedge i_clk_fpga or negedge reset) begin
    if (!reset) begin
      phase <= '0;
      slot  <= SLOT0;
    end else begin
      phase <= phase_nxt;
      slot  <= slot_nxt;
    end
  end

  always_comb begin
    phase_wrap = (phase == PHASE_LAST);
    phase_nxt  = phase_wrap ? '0 : phase + phase_t'(1);
    slot_nxt   = slot;
    if (phase_wrap) begin
      case (slot)
        SLOT0:   slot_nxt = SLOT1;
        SLOT1:   slot_nxt = SLOT2;
        default: slot_nxt = SLOT0;
      endcase
    end
    frame_bnd = phase_wrap && (slot == SLOT2);
  end

  // Ready depends only on the registered flag, so valid never reaches ready combinationally.
  assign val_if.o_val_ready = ~pend_flag;
  assign xfer = val_if.i_val_valid && ~pend_flag;

  always_ff @(posedge i_clk_fpga or negedge reset) begin
    if (!reset) begin
      disp_reg  <= '0;
      pend_reg  <= '0;
      pend_flag <= 1'b0;
    end else if (frame_bnd && pend_flag) begin
      disp_reg  <= pend_reg;
      pend_flag <= 1'b0;
    end else if (xfer) begin
      pend_reg  <= val_if.i_val;
      pend_flag <= 1'b1;
    end
  end

  always_comb begin
    nib       = '0;
    onehot    = '0;
    mask_bit  = 1'b0;
    lzb_blank = 1'b0;
    case (slot)
      SLOT0: begin
        nib      = disp_reg[3:0];
        onehot   = 3'b100;
        mask_bit = i_dig_mask[0];
      end
      SLOT1: begin
        nib       = disp_reg[7:4];
        onehot    = 3'b010;
        mask_bit  = i_dig_mask[1];
        lzb_blank = (disp_reg[11:8] == 4'd0) && (disp_reg[7:4] == 4'd0);
      end
      SLOT2: begin
        nib       = disp_reg[11:8];
        onehot    = 3'b001;
        mask_bit  = i_dig_mask[2];
        lzb_blank = (disp_reg[11:8] == 4'd0);
      end
      default: ;
    endcase
    in_blank = (BLANK_CYC != 0) && (phase < BLANK_END);
    seg_nxt  = (in_blank || !mask_bit || (i_lzb && lzb_blank)) ? 3'b000 : onehot;
  end

  always_ff @(posedge i_clk_fpga or negedge reset) begin
    if (!reset) begin
      o_seg_en      <= '0;
      o_digit       <= '0;
      o_frame_start <= 1'b0;
    end else begin
      o_seg_en      <= seg_nxt;
      o_digit       <= nib;
      o_frame_start <= (phase == '0) && (slot == SLOT0);
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl: cycle-count reference model feeds an
// expectation queue that a negedge monitor drains against the DUT outputs.
module tb_seg_scan_ctrl;

  localparam int unsigned SD    = 8;
  localparam int unsigned BC    = 2;
  localparam int unsigned FRAME = 3 * SD;

  logic       i_clk_fpga = 1'b0;
  logic       reset      = 1'b1;
  logic [2:0] i_dig_mask = 3'b111;
  logic       i_lzb      = 1'b0;
  logic [3:0] o_digit;
  logic [2:0] o_seg_en;
  logic       o_frame_start;

  seg_scan_ctrl_if vif();

  seg_scan_ctrl #(.SCAN_DIV(SD), .BLANK_CYC(BC)) dut (
    .i_clk_fpga    (i_clk_fpga),
    .reset         (reset),
    .val_if        (vif),
    .i_dig_mask    (i_dig_mask),
    .i_lzb         (i_lzb),
    .o_digit       (o_digit),
    .o_seg_en      (o_seg_en),
    .o_frame_start (o_frame_start)
  );

  always #5 i_clk_fpga = ~i_clk_fpga;

  typedef struct packed {
    logic [2:0] seg;
    logic [3:0] dig;
    logic       fs;
    logic       rdy;
  } exp_t;

  exp_t        expq[$];
  logic [11:0] m_pend[$];
  logic [11:0] m_disp;
  int unsigned m_t;
  int unsigned n_acc = 0;
  int unsigned n_off = 0;
  int          n_vec = 0;
  int          n_err = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: everything derives from the number of edges since reset release.
  initial begin : model
    int unsigned slot, p;
    logic [3:0]  n2, n1;
    bit          hide;
    exp_t        e;
    m_t    = 0;
    m_disp = '0;
    forever begin
      @(posedge i_clk_fpga or negedge reset);
      if (!reset) begin
        expq.delete();
        m_pend.delete();
        m_t    = 0;
        m_disp = '0;
      end else begin
        slot  = (m_t / SD) % 3;
        p     = m_t % SD;
        n2    = m_disp[11:8];
        n1    = m_disp[7:4];
        hide  = (p < BC) || !i_dig_mask[slot] ||
                (i_lzb && ((slot == 2 && n2 == 0) || (slot == 1 && n2 == 0 && n1 == 0)));
        e.seg = hide ? 3'b000 : (3'b100 >> slot);
        e.dig = 4'(m_disp >> (4 * slot));
        e.fs  = ((m_t % FRAME) == 0);
        if ((m_t % FRAME) == FRAME - 1 && m_pend.size() > 0)
          m_disp = m_pend.pop_front();
        else if (vif.i_val_valid && m_pend.size() == 0) begin
          m_pend.push_back(vif.i_val);
          n_acc++;
        end
        e.rdy = (m_pend.size() == 0);
        expq.push_back(e);
        m_t++;
      end
    end
  end

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge i_clk_fpga);
      if (!reset) begin
        chk("rst_seg_en", int'(o_seg_en), 0);
        chk("rst_digit", int'(o_digit), 0);
        chk("rst_frame_start", int'(o_frame_start), 0);
        chk("rst_ready", int'(vif.o_val_ready), 1);
      end else if (expq.size() > 0) begin
        e = expq.pop_front();
        chk("seg_en", int'(o_seg_en), int'(e.seg));
        chk("digit", int'(o_digit), int'(e.dig));
        chk("frame_start", int'(o_frame_start), int'(e.fs));
        chk("ready", int'(vif.o_val_ready), int'(e.rdy));
      end
    end
  end

  task automatic step();
    @(posedge i_clk_fpga);
    #2;
  endtask

  task automatic offer(input logic [11:0] v);
    int unsigned w = 0;
    vif.i_val       = v;
    vif.i_val_valid = 1'b1;
    while (!vif.o_val_ready && w < 4 * FRAME) begin
      step();
      w++;
    end
    if (!vif.o_val_ready) begin
      chk("offer_ready_timeout", int'(vif.o_val_ready), 1);
      vif.i_val_valid = 1'b0;
    end else begin
      step();
      n_off++;
      vif.i_val_valid = 1'b0;
    end
  endtask

  task automatic wait_pos(input int unsigned k);
    int unsigned w = 0;
    while ((m_t % FRAME) != k && w < 2 * FRAME) begin
      step();
      w++;
    end
    if ((m_t % FRAME) != k) begin
      n_err++;
      $display("FAIL wait_pos: got %0d expected %0d", m_t % FRAME, k);
    end
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    logic [11:0] lzb_vals[3];
    lzb_vals[0] = 12'h007;
    lzb_vals[1] = 12'h000;
    lzb_vals[2] = 12'h205;
    vif.i_val       = '0;
    vif.i_val_valid = 1'b0;
    #1 reset = 1'b0;
    repeat (3) step();
    reset = 1'b1;

    // idle scan, all zeros
    repeat (2 * FRAME) step();

    // load inside the idx1 slot
    wait_pos(SD + 3);
    offer(12'h123);
    repeat (2 * FRAME) step();

    // back-to-back with valid held across the gap
    repeat ($urandom_range(0, FRAME - 1)) step();
    offer(12'h456);
    offer(12'h789);
    repeat (3 * FRAME) step();

    i_lzb = 1'b1;
    foreach (lzb_vals[i]) begin
      offer(lzb_vals[i]);
      repeat (FRAME) step();
    end
    repeat (FRAME) step();
    i_lzb = 1'b0;

    i_dig_mask = 3'b010;
    repeat (2 * FRAME) step();
    i_dig_mask = 3'b111;

    // reset in the idx1 show window while a value is pending
    wait_pos(0);
    offer(12'h987);
    wait_pos(SD + 4);
    reset = 1'b0;
    #1;
    chk("rst_imm_seg_en", int'(o_seg_en), 0);
    chk("rst_imm_ready", int'(vif.o_val_ready), 1);
    repeat (3) step();
    reset = 1'b1;
    repeat (2 * FRAME) step();

    // randomized traffic with live mask/lzb changes
    repeat (300) begin
      vif.i_val_valid = 1'($urandom_range(0, 1));
      vif.i_val       = 12'($urandom);
      if ($urandom_range(0, 7) == 0) i_dig_mask = 3'($urandom);
      if ($urandom_range(0, 7) == 0) i_lzb = 1'($urandom);
      if (vif.i_val_valid && vif.o_val_ready) n_off++;
      step();
    end
    vif.i_val_valid = 1'b0;
    repeat (2 * FRAME) step();

    chk("accept_count", int'(n_acc), int'(n_off));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
- Time-multiplexing scheduler for the board's 3-digit seven-segment display.
- Shares the single segment bus between three digit slots.
- Accepts a new 3-digit BCD value through a valid/ready handshake, double-buffers it and applies it only at frame boundaries, so no torn digits appear.
- Sits between the counter logic and the existing BCD-to-segment decoder: o_digit feeds the decoder and o_seg_en drives the digit enables.

Parameters:
- SCAN_DIV, 100_000: clock cycles per digit slot (1 kHz slot rate at 100 MHz). Must be ≥ BLANK_CYC+1.
- BLANK_CYC, 1_000: cycles at the start of each slot with all digits off (anti-ghosting). 0 disables blanking.

Ports:
- i_clk_fpga, input, 1: system clock, 100 MHz.
- reset, input, 1: asynchronous, active-low reset.
- i_val, input, 12: BCD value. [3:0] is digit idx0 (rightmost), [7:4] is idx1, [11:8] is idx2 (leftmost).
- i_val_valid, input, 1: i_val is offered.
- o_val_ready, output, 1: block can accept a value.
- i_dig_mask, input, 3: per-slot enable. Bit i enables idx i.
- i_lzb, input, 1: leading-zero blanking enable.
- o_digit, output, 4: nibble of the currently scanned slot, to the decoder.
- o_seg_en, output, 3: one-hot digit enable, active-high. idx0=3'b100, idx1=3'b010, idx2=3'b001.
- o_frame_start, output, 1: one-cycle pulse at the start of each frame.

Behaviour:
- Reset (async, reset=0): phase=0, idx=0, disp_reg=0, pend_reg=0, pend_flag=0, o_seg_en=0, o_digit=0, o_frame_start=0, o_val_ready=1.
- Phase counter:
  - Counts 0..SCAN_DIV-1 and wraps.
  - On wrap, idx advances 0→1→2→0.
- Frame boundary: the cycle where phase==SCAN_DIV-1 and idx==2.
- Outputs are registered, one cycle latency. State (phase p, idx i) in cycle n determines outputs in cycle n+1:
  - o_seg_en = 0 if p < BLANK_CYC, or i_dig_mask[i]==0, or slot i is LZB-blanked. Otherwise the one-hot code for i.
  - o_digit = disp_reg nibble i. This holds during blank slots too.
  - o_frame_start = 1 iff p==0 and i==0.
- Leading-zero blanking (i_lzb=1, evaluated on disp_reg):
  - idx2 is blanked if nibble2==0.
  - idx1 is blanked if nibble2==0 and nibble1==0.
  - idx0 is never blanked.
  - With i_lzb=0, no blanking is applied.
- Nibbles >9 pass through unmodified. Decoding them is the decoder's job.
- Handshake:
  - o_val_ready = ~pend_flag.
  - A transfer occurs when i_val_valid && o_val_ready on a rising edge: pend_reg←i_val, pend_flag←1.
  - i_val_valid while ready=0 is ignored, with no queueing.
  - The producer may hold valid. A new transfer happens once ready returns.
- Apply:
  - At a frame boundary with pend_flag=1 (set before that edge): disp_reg←pend_reg, pend_flag←0.
  - A transfer on the same edge as a frame boundary with pend_flag=0 is captured into pend_reg and applied at the next frame boundary.
- i_dig_mask and i_lzb are sampled live every cycle and are not buffered.
- Reset mid-operation: immediate blank (o_seg_en=0). Any pending value is discarded. After release the scan restarts at idx0, phase 0, in the blank window.
- No combinational path from i_val_valid to o_val_ready.

Test Plan (SCAN_DIV=8, BLANK_CYC=2, mask=3'b111, lzb=0 unless stated):
1. Release reset with no load:
   - Per 24-cycle frame, o_seg_en = 2×000, 6×100, 2×000, 6×010, 2×000, 6×001.
   - o_digit=0 throughout.
   - o_frame_start pulses every 24 cycles, first pulse one cycle after release.
2. Offer 12'h123 in the idx1 slot:
   - Accepted in 1 cycle; ready=0 until the boundary.
   - Display stays 000 for the rest of the frame.
   - Next frame shows o_digit=3 with 100, 2 with 010, 1 with 001.
   - Ready=1 the cycle after the boundary.
3. Offer 12'h456 then 12'h789 back-to-back with valid held:
   - 456 applied at boundary 1.
   - 789 accepted after ready rises and applied at boundary 2.
   - No value dropped while valid is held.
4. lzb=1:
   - Value 12'h007: only idx0 lit, showing 7. idx1 and idx2 slots show 000.
   - Value 12'h000: only idx0 lit, showing 0.
   - Value 12'h205: all three lit.
5. i_dig_mask=3'b010: only the idx1 slot is ever lit (010). Other slots show 000.
6. Assert reset during the idx1 show window with a value pending:
   - o_seg_en=000 immediately, ready=1.
   - After release, disp_reg=0 and the scan restarts at idx0 with 2 blank cycles.
